writeback_regfile: RTL and testbench

Integer register file with pending-write scoreboard for the RISC V pipeline. It is the receiving end of the write-back path: it takes the selected write-back value (PC, ALU, memory or immediate result) and its destination register. It exposes two bypassed read ports to decode, and tracks in-flight destination registers so decode can stall on read-after-write hazards.

---
 rtl/writeback_regfile.sv | 86 ++++++++
 tb/tb_writeback_regfile.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/writeback_regfile.sv
// Integer register file with bypassed read ports and a per-register in-flight
// write counter that lets decode stall on read-after-write hazards.
module writeback_regfile #(
  parameter int WIDTH    = 32,
  parameter int CNT_BITS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs1Addr,
  input  logic [4:0]       rs2Addr,
  input  logic             rs1Use,
  input  logic             rs2Use,
  output logic [WIDTH-1:0] rs1Data,
  output logic [WIDTH-1:0] rs2Data,
  input  logic             issueValid,
  input  logic [4:0]       issueRd,
  output logic             issueAccept,
  output logic             stall,
  input  logic             wbValid,
  input  logic [4:0]       wbRd,
  input  logic [WIDTH-1:0] wbData,
  input  logic             flush
);

  localparam logic [CNT_BITS-1:0] CntMax = {CNT_BITS{1'b1}};
  localparam logic [CNT_BITS-1:0] CntOne = CNT_BITS'(1);

  logic [WIDTH-1:0]    regs [0:31];
  logic [CNT_BITS-1:0] cnt  [0:31];

  logic [CNT_BITS-1:0] cnt1, cnt2, cntIssue;
  logic                haz1, haz2, full;
  logic [31:0]         incVec, decVec;

  // Handshake: decode holds issueValid/issueRd steady; the issue is taken and
  // the destination counted busy only in a cycle where issueAccept is high.
  always_comb begin
    cnt1     = cnt[rs1Addr];
    cnt2     = cnt[rs2Addr];
    cntIssue = cnt[issueRd];

    rs1Data = regs[rs1Addr];
    if (rs1Addr == 5'd0)                   rs1Data = '0;
    else if (wbValid && wbRd == rs1Addr)   rs1Data = wbData;

    rs2Data = regs[rs2Addr];
    if (rs2Addr == 5'd0)                   rs2Data = '0;
    else if (wbValid && wbRd == rs2Addr)   rs2Data = wbData;

    // A write-back retiring the last outstanding write resolves the hazard now.
    haz1 = rs1Use && (rs1Addr != 5'd0) && (cnt1 != '0)
           && !(wbValid && (wbRd == rs1Addr) && (cnt1 == CntOne));
    haz2 = rs2Use && (rs2Addr != 5'd0) && (cnt2 != '0)
           && !(wbValid && (wbRd == rs2Addr) && (cnt2 == CntOne));
    full = (issueRd != 5'd0) && (cntIssue == CntMax)
           && !(wbValid && (wbRd == issueRd));

    stall       = haz1 || haz2 || (issueValid && full);
    issueAccept = issueValid && !stall && !flush;

    incVec = '0;
    decVec = '0;
    for (int r = 1; r < 32; r++) begin
      incVec[r] = issueAccept && (issueRd == 5'(r));
      decVec[r] = wbValid && (wbRd == 5'(r)) && (cnt[r] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
    end else begin
      if (wbValid && wbRd != 5'd0) regs[wbRd] <= wbData;
      cnt[0] <= '0;
      for (int r = 1; r < 32; r++) begin
        if (flush)                          cnt[r] <= '0;
        else if (incVec[r] && !decVec[r])   cnt[r] <= cnt[r] + CntOne;
        else if (decVec[r] && !incVec[r])   cnt[r] <= cnt[r] - CntOne;
      end
    end
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// Bench for writeback_regfile: directed scenarios then random traffic, checked
// against a behavioural register/busy-count model through an expected queue.
module tb_writeback_regfile;

  localparam int W = 32;
  localparam int EW = 2 * W + 2;

  logic         clk;
  logic         rst_n;
  logic [4:0]   rs1Addr, rs2Addr, issueRd, wbRd;
  logic         rs1Use, rs2Use, issueValid, wbValid, flush;
  logic [W-1:0] rs1Data, rs2Data, wbData;
  logic         issueAccept, stall;

  int n_checks = 0;
  int n_fail   = 0;

  logic [EW-1:0] exp_q[$];

  // Reference model: architectural values and outstanding-write counts.
  logic [W-1:0] m_mem  [32];
  int           m_busy [32];

  writeback_regfile #(.WIDTH(W), .CNT_BITS(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1Addr(rs1Addr), .rs2Addr(rs2Addr), .rs1Use(rs1Use), .rs2Use(rs2Use),
    .rs1Data(rs1Data), .rs2Data(rs2Data),
    .issueValid(issueValid), .issueRd(issueRd), .issueAccept(issueAccept),
    .stall(stall),
    .wbValid(wbValid), .wbRd(wbRd), .wbData(wbData), .flush(flush)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] model_read(input logic [4:0] a);
    if (a == 5'd0) return '0;
    if (wbValid && wbRd == a) return wbData;
    return m_mem[a];
  endfunction

  function automatic logic model_haz(input logic [4:0] a, input logic u);
    if (!u || a == 5'd0 || m_busy[a] == 0) return 1'b0;
    // the single outstanding write arriving now clears the dependency
    if (wbValid && wbRd == a && m_busy[a] == 1) return 1'b0;
    return 1'b1;
  endfunction

  // Driver: apply one cycle of inputs, queue the expected outputs, then
  // advance the model across the coming rising edge.
  task automatic drive(input logic rst, input logic [4:0] a1, input logic u1,
                       input logic [4:0] a2, input logic u2,
                       input logic iv, input logic [4:0] ird,
                       input logic wv, input logic [4:0] wrd,
                       input logic [W-1:0] wd, input logic fl, input logic chk);
    logic e_stall, e_acc, full, inc, dec;
    @(negedge clk);
    rst_n = ~rst; rs1Addr = a1; rs1Use = u1; rs2Addr = a2; rs2Use = u2;
    issueValid = iv; issueRd = ird; wbValid = wv; wbRd = wrd; wbData = wd;
    flush = fl;
    full    = (ird != 5'd0) && (m_busy[ird] == 3) && !(wv && wrd == ird);
    e_stall = model_haz(a1, u1) || model_haz(a2, u2) || (iv && full);
    e_acc   = iv && !e_stall && !fl;
    if (chk) exp_q.push_back({model_read(a1), model_read(a2), e_stall, e_acc});
    if (rst) begin
      for (int r = 0; r < 32; r++) begin m_mem[r] = '0; m_busy[r] = 0; end
    end else begin
      if (wv && wrd != 5'd0) m_mem[wrd] = wd;
      if (fl) begin
        for (int r = 0; r < 32; r++) m_busy[r] = 0;
      end else begin
        inc = e_acc && ird != 5'd0;
        dec = wv && wrd != 5'd0 && m_busy[wrd] > 0;
        if (inc) m_busy[ird] = m_busy[ird] + 1;
        if (dec) m_busy[wrd] = m_busy[wrd] - 1;
      end
    end
  endtask

  task automatic idle_read(input logic [4:0] a1, input logic u1,
                           input logic [4:0] a2, input logic u2);
    drive(1'b0, a1, u1, a2, u2, 1'b0, 5'd0, 1'b0, 5'd0, '0, 1'b0, 1'b1);
  endtask

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: outputs are combinational, so one sample per cycle.
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rs1Data", rs1Data, e[EW-1 -: W]);
        check("rs2Data", rs2Data, e[W+1 -: W]);
        check("stall", {31'd0, stall}, {31'd0, e[1]});
        check("issueAccept", {31'd0, issueAccept}, {31'd0, e[0]});
      end
    end
  end

  initial begin
    logic [4:0] a1, a2, ird, wrd;
    rst_n = 1'b0; rs1Addr = '0; rs2Addr = '0; rs1Use = 1'b0; rs2Use = 1'b0;
    issueValid = 1'b0; issueRd = '0; wbValid = 1'b0; wbRd = '0; wbData = '0;
    flush = 1'b0;

    // reset for two cycles, then read after reset
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, '0, 1'b0, 1'b0);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, '0, 1'b0, 1'b0);
    drive(1'b0, 5'd5, 1'b1, 5'd0, 1'b1, 1'b1, 5'd1, 1'b0, 5'd0, '0, 1'b0, 1'b1);
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, '0, 1'b0, 1'b0);

    // write and bypass, array read next cycle, x0 never written
    drive(1'b0, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 1'b1);
    idle_read(5'd7, 1'b0, 5'd7, 1'b0);
    drive(1'b0, 5'd0, 1'b0, 5'd7, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 32'h1234, 1'b0, 1'b1);
    idle_read(5'd0, 1'b0, 5'd7, 1'b0);

    // RAW stall and same-cycle resolve
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 5'd0, '0, 1'b0, 1'b1);
    drive(1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, '0, 1'b0, 1'b1);
    drive(1'b0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 5'd3, 32'h55, 1'b0, 1'b1);

    // rsUse gating
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 5'd0, '0, 1'b0, 1'b1);
    drive(1'b0, 5'd0, 1'b0, 5'd4, 1'b0, 1'b1, 5'd6, 1'b0, 5'd0, '0, 1'b0, 1'b1);

    // counter saturation, then issue allowed by a same-cycle write-back
    for (int i = 0; i < 3; i++)
      drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 5'd0, '0, 1'b0, 1'b1);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 5'd0, '0, 1'b0, 1'b1);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 1'b1, 5'd9, 32'h99, 1'b0, 1'b1);
    idle_read(5'd9, 1'b1, 5'd9, 1'b0);

    // flush clears busy; stray write-back still writes
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd10, 1'b0, 5'd0, '0, 1'b0, 1'b1);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd11, 1'b0, 5'd0, '0, 1'b0, 1'b1);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd12, 1'b0, 5'd0, '0, 1'b1, 1'b1);
    idle_read(5'd10, 1'b1, 5'd11, 1'b1);
    drive(1'b0, 5'd10, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd10, 32'h77, 1'b0, 1'b1);
    idle_read(5'd10, 1'b1, 5'd12, 1'b1);

    // random traffic on a narrow register window to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      a1  = 5'($urandom_range(0, 12));
      a2  = 5'($urandom_range(0, 12));
      ird = 5'($urandom_range(0, 12));
      wrd = 5'($urandom_range(0, 12));
      drive(($urandom_range(0, 199) == 0), a1, 1'($urandom_range(0, 1)),
            a2, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), ird,
            ($urandom_range(0, 2) != 0), wrd, $urandom,
            ($urandom_range(0, 99) == 0), 1'b1);
    end

    idle_read(5'd0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    #5;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
